// File: rtl/vga_timing_recovery.sv
// Sink-side VGA timing recovery: locks to hsync/vsync periods and regenerates x/y/active.
// Optional VGA_RX_STATS_EN adds frame_cnt/err_cnt statistics outputs.
module vga_timing_recovery #(
    parameter int H_BACK_PORCH = 48,
    parameter int H_ACTIVE     = 640,
    parameter int V_BACK_PORCH = 31,
    parameter int V_ACTIVE     = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic        locked,
    output logic        err,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines
`ifdef VGA_RX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] HBP     = 11'(H_BACK_PORCH);
    localparam logic [10:0] HEND    = 11'(H_BACK_PORCH + H_ACTIVE);
    localparam logic [10:0] VBP     = 11'(V_BACK_PORCH);
    localparam logic [10:0] VEND    = 11'(V_BACK_PORCH + V_ACTIVE);

    state_t      state, state_nx;
    logic        hs_q, vs_q;
    logic        hrise, vrise;
    logic [10:0] hcnt, vcnt;
    logic [10:0] hlen;
    logic        hsat;
    logic        loss;
    logic        seen_h, have_cap, stable;
    logic        h_in, v_in;

    assign hrise = hsync_in & ~hs_q;
    assign vrise = vsync_in & ~vs_q;
    assign hlen  = hcnt + 11'd1;
    assign hsat  = (hcnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) state <= SEARCH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        loss     = 1'b0;
        case (state)
            SEARCH: if (vrise) state_nx = MEASURE;
            MEASURE: begin
                if (hsat)                state_nx = SEARCH;
                else if (vrise && stable) state_nx = LOCKED;
            end
            LOCKED: begin
                loss = (hrise && (hlen != line_len)) ||
                       (vrise && (vcnt != frame_lines)) || hsat;
                if (loss) state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hcnt        <= '0;
            vcnt        <= '0;
            err         <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            seen_h      <= 1'b0;
            have_cap    <= 1'b0;
            stable      <= 1'b0;
        end else begin
            hs_q <= hsync_in;
            vs_q <= vsync_in;
            err  <= loss;

            if (hrise)      hcnt <= '0;
            else if (!hsat) hcnt <= hcnt + 11'd1;

            // vrise wins over a coincident hrise so the new frame starts at row 0
            if (vrise)                           vcnt <= '0;
            else if (hrise && vcnt != CNT_MAX)   vcnt <= vcnt + 11'd1;

            if (state == MEASURE) begin
                if (hrise) begin
                    seen_h <= 1'b1;
                    // the first hrise only opens the measurement window
                    if (seen_h) begin
                        line_len <= hlen;
                        stable   <= have_cap && (hlen == line_len);
                        have_cap <= 1'b1;
                    end
                end
                if (vrise && stable && !hsat) frame_lines <= vcnt;
                if (vrise && !stable) begin
                    have_cap <= 1'b0;
                    stable   <= 1'b0;
                end
            end else begin
                seen_h   <= 1'b0;
                have_cap <= 1'b0;
                stable   <= 1'b0;
            end
        end
    end

    assign locked = (state == LOCKED);
    assign h_in   = (hcnt >= HBP) && (hcnt < HEND);
    assign v_in   = (vcnt >= VBP) && (vcnt < VEND);
    assign active = locked && h_in && v_in;
    assign x      = active ? 10'(hcnt - HBP) : 10'd0;
    assign y      = active ? 10'(vcnt - VBP) : 10'd0;

`ifdef VGA_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (vrise && state == LOCKED) frame_cnt <= frame_cnt + 16'd1;
            if (err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Scoreboarded bench for vga_timing_recovery on a reduced 100x20 raster.
// Stats checks compile in when VGA_RX_STATS_EN is defined.
module tb_vga_timing_recovery;

    // Reduced raster: sync ends H_BP/V_BP before the generator origin, so
    // active pixel (x,y) coincides with generator position (x,y).
    localparam int H_TOT  = 100;
    localparam int H_SYNC = 80;
    localparam int H_RISE = 92;
    localparam int H_BP   = H_TOT - H_RISE;
    localparam int H_ACT  = 64;
    localparam int V_TOT  = 20;
    localparam int V_SYNC = 14;
    localparam int V_RISE = 16;
    localparam int V_BP   = V_TOT - V_RISE;
    localparam int V_ACT  = 12;

    typedef struct {
        logic       a;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, hsync_in, vsync_in;
    logic [9:0]  x, y;
    logic        active, locked, err;
    logic [10:0] line_len, frame_lines;
`ifdef VGA_RX_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    int vectors = 0, miscompares = 0;
    int gen_hc = 0, gen_vc = 0, s_hc = 0, s_vc = 0, voff = 0, short_ln = 0;
    bit short_pend = 0, hold = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vga_timing_recovery #(
        .H_BACK_PORCH(H_BP), .H_ACTIVE(H_ACT), .V_BACK_PORCH(V_BP), .V_ACTIVE(V_ACT)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .active(active), .locked(locked), .err(err),
        .line_len(line_len), .frame_lines(frame_lines)
`ifdef VGA_RX_STATS_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    // Drive the current generator position, let the DUT sample it, then advance.
    task automatic tick();
        int pos;
        int lim;
        pos = gen_vc * H_TOT + gen_hc;
        if (hold) begin
            hsync_in = 1'b1;
            vsync_in = 1'b1;
        end else begin
            hsync_in = !(gen_hc >= H_SYNC && gen_hc < H_RISE);
            vsync_in = !(pos >= V_SYNC * H_TOT + voff && pos < V_RISE * H_TOT + voff);
        end
        s_hc = gen_hc;
        s_vc = gen_vc;
        @(posedge clk);
        @(negedge clk);
        lim = (short_pend && gen_vc == short_ln) ? H_TOT - 1 : H_TOT;
        gen_hc++;
        if (gen_hc >= lim) begin
            if (short_pend && gen_vc == short_ln) short_pend = 0;
            gen_hc = 0;
            gen_vc = (gen_vc + 1) % V_TOT;
        end
    endtask

    task automatic advance_to(input int l, input int h);
        for (int i = 0; i < H_TOT * V_TOT + 1; i++) begin
            tick();
            if (s_vc == l && s_hc == h) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({locked, err, active} !== 3'b000 || x !== 10'd0 || y !== 10'd0 ||
            line_len !== 11'd0 || frame_lines !== 11'd0) begin
            miscompares++;
            $display("FAIL reset: locked=%b err=%b active=%b x=%0d y=%0d len=%0d lines=%0d, want all 0",
                     locked, err, active, x, y, line_len, frame_lines);
        end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        advance_to(V_RISE, 0);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_first_vrise: locked=%b want 0", locked); end
        advance_to(V_RISE - 1, H_TOT - 1);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_early: locked=%b want 0", locked); end
        tick();
        vectors++;
        if (locked !== 1'b1 || line_len !== 11'(H_TOT) || frame_lines !== 11'(V_TOT)) begin
            miscompares++;
            $display("FAIL lock_second_vrise: locked=%b len=%0d lines=%0d, want 1 %0d %0d",
                     locked, line_len, frame_lines, H_TOT, V_TOT);
        end
    endtask

    task automatic test_clean_frame();
        int cnt[V_TOT];
        int full_lines, total, errs;
        exp_t e, o;
        for (int i = 0; i < V_TOT; i++) cnt[i] = 0;
        errs = 0;
        for (int i = 0; i < H_TOT * V_TOT; i++) begin
            int hm, vm;
            hm = (gen_hc + H_TOT - H_RISE) % H_TOT;
            vm = (gen_vc + V_TOT - V_RISE) % V_TOT + ((gen_hc >= H_RISE) ? 1 : 0);
            e.a = (hm >= H_BP && hm < H_BP + H_ACT && vm >= V_BP && vm < V_BP + V_ACT);
            e.x = e.a ? 10'(hm - H_BP) : 10'd0;
            e.y = e.a ? 10'(vm - V_BP) : 10'd0;
            sb.push_back(e);
            tick();
            o = sb.pop_front();
            vectors++;
            if (active !== o.a || x !== o.x || y !== o.y) begin
                miscompares++;
                $display("FAIL pixel(%0d,%0d): got a=%b x=%0d y=%0d want a=%b x=%0d y=%0d",
                         s_hc, s_vc, active, x, y, o.a, o.x, o.y);
            end
            if (active) cnt[s_vc]++;
            if (err) errs++;
        end
        full_lines = 0;
        total = 0;
        for (int i = 0; i < V_TOT; i++) begin
            if (cnt[i] == H_ACT) full_lines++;
            total += cnt[i];
        end
        vectors++;
        if (full_lines != V_ACT || total != V_ACT * H_ACT) begin
            miscompares++;
            $display("FAIL active_count: lines=%0d total=%0d want %0d %0d", full_lines, total, V_ACT, V_ACT * H_ACT);
        end
        vectors++;
        if (errs != 0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_stable: err pulses=%0d locked=%b want 0 1", errs, locked);
        end
    endtask

    task automatic test_short_line();
        advance_to(4, H_TOT - 1);
        short_pend = 1;
        short_ln = 5;
        advance_to(6, H_RISE - 1);
        vectors++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            miscompares++; $display("FAIL short_pre: locked=%b err=%b want 1 0", locked, err);
        end
        tick();
        vectors++;
        if (locked !== 1'b0 || err !== 1'b1 || line_len !== 11'(H_TOT)) begin
            miscompares++;
            $display("FAIL short_hit: locked=%b err=%b len=%0d want 0 1 %0d", locked, err, line_len, H_TOT);
        end
        tick();
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL short_pulse: err=%b want 0", err); end
        advance_to(V_RISE, 0);
        advance_to(V_RISE - 1, H_TOT - 1);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL short_relock_early: locked=%b want 0", locked); end
        tick();
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL short_relock: locked=%b want 1", locked); end
    endtask

    task automatic test_hsync_stuck();
        int errs, err_at, act;
        errs = 0; err_at = -1; act = 0;
        advance_to(17, H_RISE);
        hold = 1;
        for (int j = 1; j <= 2100; j++) begin
            tick();
            if (err) begin errs++; err_at = j; end
            if (active) act++;
        end
        hold = 0;
        vectors++;
        if (errs != 1 || err_at < 2046 || err_at > 2049) begin
            miscompares++; $display("FAIL stuck_err: pulses=%0d at=%0d want 1 near 2048", errs, err_at);
        end
        vectors++;
        if (act != 0 || locked !== 1'b0) begin
            miscompares++; $display("FAIL stuck_state: active cycles=%0d locked=%b want 0 0", act, locked);
        end
        advance_to(V_RISE, 0);
        advance_to(V_RISE, 0);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL stuck_relock: locked=%b want 1", locked); end
    endtask

    task automatic test_coincident();
        advance_to(10, 0);
        voff = H_RISE;
        advance_to(V_RISE, H_RISE - 1);
        tick();
        voff = 0;
        vectors++;
        if (locked !== 1'b1 || err !== 1'b0 || frame_lines !== 11'(V_TOT) || dut.vcnt !== 11'd0) begin
            miscompares++;
            $display("FAIL coincident: locked=%b err=%b lines=%0d vcnt=%0d want 1 0 %0d 0",
                     locked, err, frame_lines, dut.vcnt, V_TOT);
        end
    endtask

    task automatic test_mid_reset();
        advance_to(2, 30);
        vectors++;
        if (active !== 1'b1 || x !== 10'd30 || y !== 10'd1) begin
            miscompares++; $display("FAIL mid_pre: active=%b x=%0d y=%0d want 1 30 1", active, x, y);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        vectors++;
        if ({locked, err, active} !== 3'b000 || x !== 10'd0 || y !== 10'd0 ||
            line_len !== 11'd0 || frame_lines !== 11'd0) begin
            miscompares++;
            $display("FAIL mid_reset: locked=%b err=%b active=%b x=%0d y=%0d len=%0d lines=%0d, want all 0",
                     locked, err, active, x, y, line_len, frame_lines);
        end
        advance_to(V_RISE, 0);
        advance_to(V_RISE, 0);
        vectors++;
        if (locked !== 1'b1 || line_len !== 11'(H_TOT) || frame_lines !== 11'(V_TOT)) begin
            miscompares++;
            $display("FAIL mid_relock: locked=%b len=%0d lines=%0d want 1 %0d %0d",
                     locked, line_len, frame_lines, H_TOT, V_TOT);
        end
    endtask

`ifdef VGA_RX_STATS_EN
    task automatic test_stats();
        repeat (3) advance_to(V_RISE, 0);
        advance_to(4, H_TOT - 1);
        short_pend = 1;
        short_ln = 5;
        advance_to(7, 0);
        vectors++;
        if (frame_cnt !== 16'd3 || err_cnt !== 16'd1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL stats: frame_cnt=%0d err_cnt=%0d locked=%b want 3 1 0", frame_cnt, err_cnt, locked);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        @(negedge clk);
        test_reset();
        test_lock();
        test_clean_frame();
        test_short_line();
        test_hsync_stuck();
        test_coincident();
        test_mid_reset();
`ifdef VGA_RX_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
